// File: rtl/ifetch_queue.sv
// ifetch_queue: instruction fetch stage. Owns the PC, issues word fetches over a
// request/grant bus with in-order responses, buffers returned words in a small
// FIFO and hands {instr, pc} to decode with a valid/ready handshake.
// Optional feature macro: IFETCH_MISALIGN_CHK_EN (misaligned redirect targets
// produce a single fault entry and halt fetching until the next redirect).
//
// state | meaning
// BOOT  | first cycle out of reset, no request issued
// RUN   | normal fetch; requests while buffered+outstanding leaves room
// FLUSH | dropping responses that belong to the pre-redirect stream
module ifetch_queue #(
  parameter int                  WORDSIZE = 32,
  parameter logic [WORDSIZE-1:0] RESET_PC = '0,
  parameter int                  DEPTH    = 2
) (
  input  logic                clk,
  input  logic                rst,
  output logic                imem_req,
  output logic [WORDSIZE-1:0] imem_addr,
  input  logic                imem_gnt,
  input  logic                imem_rvalid,
  input  logic [WORDSIZE-1:0] imem_rdata,
  input  logic                redirect,
  input  logic [WORDSIZE-1:0] redirect_pc,
  output logic                id_valid,
  input  logic                id_ready,
  output logic [WORDSIZE-1:0] id_instr,
  output logic [WORDSIZE-1:0] id_pc,
  output logic                id_fault
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [WORDSIZE-1:0] NOP     = WORDSIZE'(32'h0000_0013);
  localparam logic [WORDSIZE-1:0] STEP    = WORDSIZE'(4);
  localparam logic [CW:0]         DEPTH_V = (CW+1)'(DEPTH);

  typedef enum logic [1:0] {BOOT = 2'd0, RUN = 2'd1, FLUSH = 2'd2} state_t;

  state_t              state;
  logic [WORDSIZE-1:0] pc;
  logic [CW-1:0]       count;
  logic [CW-1:0]       outstanding;
  logic [CW-1:0]       discard;
  logic [AW-1:0]       rd_ptr;
  logic [AW-1:0]       wr_ptr;
  logic [AW-1:0]       aq_rd;
  logic [AW-1:0]       aq_wr;
  logic [WORDSIZE-1:0] fifo_instr [DEPTH];
  logic [WORDSIZE-1:0] fifo_pc    [DEPTH];
  logic [WORDSIZE-1:0] aq_pc      [DEPTH];
  logic [CW:0]         occ;
  logic [CW:0]         disc_sum;
  logic                pop;
  logic                hs;
  logic                accept;
  logic                misalign;
  logic                halt;
  logic [WORDSIZE-1:0] target;

`ifdef IFETCH_MISALIGN_CHK_EN
  logic fifo_fault [DEPTH];

  assign misalign = |redirect_pc[1:0];
  assign target   = redirect_pc;
  assign id_fault = id_valid && fifo_fault[rd_ptr];

  // halt fetching after a misaligned redirect until the next redirect
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      halt <= 1'b0;
    else if (redirect)
      halt <= misalign;
  end

  // fault flag storage alongside the FIFO entries
  always_ff @(posedge clk) begin
    if (redirect) begin
      if (misalign)
        fifo_fault[0] <= 1'b1;
    end else if (accept) begin
      fifo_fault[wr_ptr] <= 1'b0;
    end
  end
`else
  assign misalign = 1'b0;
  assign halt     = 1'b0;
  assign target   = redirect_pc & ~WORDSIZE'(3);
  assign id_fault = 1'b0;
`endif

  assign id_valid  = (count != '0);
  assign id_instr  = id_valid ? fifo_instr[rd_ptr] : NOP;
  assign id_pc     = id_valid ? fifo_pc[rd_ptr] : '0;
  assign pop       = id_valid && id_ready;
  assign occ       = {1'b0, count} + {1'b0, outstanding};

  // A pop this cycle frees a slot, so it counts toward room for a new request;
  // this is what sustains one instruction per cycle with DEPTH=2. The request
  // is withheld during a redirect so a grant that cycle is never a handshake.
  assign imem_req  = (state == RUN) && !redirect && !halt && ((occ < DEPTH_V) || pop);
  assign imem_addr = pc;
  assign hs        = imem_req && imem_gnt;
  assign accept    = imem_rvalid && (state == RUN) && !redirect && (discard == '0);

  // In RUN discard is 0 and in FLUSH outstanding is 0, so this sum is the
  // number of stale responses still to come after a redirect.
  assign disc_sum  = {1'b0, discard} + {1'b0, outstanding} - (CW+1)'(imem_rvalid);

  // FSM, PC, occupancy counters and queue pointers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= BOOT;
      pc          <= RESET_PC;
      count       <= '0;
      outstanding <= '0;
      discard     <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      aq_rd       <= '0;
      aq_wr       <= '0;
    end else if (redirect) begin
      pc          <= target;
      outstanding <= '0;
      discard     <= disc_sum[CW-1:0];
      state       <= (disc_sum != '0) ? FLUSH : RUN;
      rd_ptr      <= '0;
      aq_rd       <= '0;
      aq_wr       <= '0;
      if (misalign) begin
        wr_ptr <= AW'(1);
        count  <= CW'(1);
      end else begin
        wr_ptr <= '0;
        count  <= '0;
      end
    end else begin
      unique case (state)
        BOOT:    state <= RUN;
        RUN:     state <= RUN;
        FLUSH: begin
          if (imem_rvalid) begin
            discard <= discard - CW'(1);
            if (discard == CW'(1))
              state <= RUN;
          end
        end
        default: state <= BOOT;
      endcase

      if (hs) begin
        pc    <= pc + STEP;
        aq_wr <= aq_wr + AW'(1);
      end
      if (accept) begin
        wr_ptr <= wr_ptr + AW'(1);
        aq_rd  <= aq_rd + AW'(1);
      end
      if (pop)
        rd_ptr <= rd_ptr + AW'(1);

      if (hs && !accept)
        outstanding <= outstanding + CW'(1);
      else if (!hs && accept)
        outstanding <= outstanding - CW'(1);

      if (accept && !pop)
        count <= count + CW'(1);
      else if (!accept && pop)
        count <= count - CW'(1);
    end
  end

  // FIFO payload and request-address queue storage
  always_ff @(posedge clk) begin
    if (redirect) begin
      if (misalign) begin
        fifo_instr[0] <= NOP;
        fifo_pc[0]    <= redirect_pc;
      end
    end else if (accept) begin
      fifo_instr[wr_ptr] <= imem_rdata;
      fifo_pc[wr_ptr]    <= aq_pc[aq_rd];
    end
    if (hs)
      aq_pc[aq_wr] <= pc;
  end

endmodule

// File: tb/tb_ifetch_queue.sv
// Directed bench for ifetch_queue: a small in-order memory model answers each
// granted request (rdata = addr ^ 32'hA5A5_0000); a second instance with a
// wrap-around RESET_PC runs alongside the first test.
module tb_ifetch_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req, imem_gnt, imem_rvalid;
  logic [31:0] imem_addr, imem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        id_valid, id_ready, id_fault;
  logic [31:0] id_instr, id_pc;

  logic        req2, gnt2, rvalid2, redirect2, valid2, ready2, fault2;
  logic [31:0] addr2, rdata2, redirect_pc2, instr2, pc2;

  logic [31:0] pend[$];
  logic        hold_rsp;
  logic        hs2_q;
  int          total = 0;
  int          bad   = 0;

  always #5 clk = ~clk;

  ifetch_queue #(.WORDSIZE(32), .RESET_PC(32'h0000_0000), .DEPTH(2)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .id_valid(id_valid), .id_ready(id_ready), .id_instr(id_instr),
    .id_pc(id_pc), .id_fault(id_fault)
  );

  ifetch_queue #(.WORDSIZE(32), .RESET_PC(32'hFFFF_FFF8), .DEPTH(2)) dut2 (
    .clk(clk), .rst(rst),
    .imem_req(req2), .imem_addr(addr2), .imem_gnt(gnt2),
    .imem_rvalid(rvalid2), .imem_rdata(rdata2),
    .redirect(redirect2), .redirect_pc(redirect_pc2),
    .id_valid(valid2), .id_ready(ready2), .id_instr(instr2),
    .id_pc(pc2), .id_fault(fault2)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // one clock: drive memory responses, record handshakes, advance to negedge+1
  task automatic tick();
    if (!hold_rsp && pend.size() > 0) begin
      imem_rvalid = 1'b1;
      imem_rdata  = pend[0] ^ 32'hA5A5_0000;
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = 32'h0;
    end
    rvalid2 = hs2_q;
    #1;
    if (imem_rvalid) void'(pend.pop_front());
    if (imem_req && imem_gnt) pend.push_back(imem_addr);
    hs2_q = req2 && gnt2;
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst         = 1'b1;
    redirect    = 1'b0;
    imem_rvalid = 1'b0;
    rvalid2     = 1'b0;
    hold_rsp    = 1'b0;
    hs2_q       = 1'b0;
    pend.delete();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
  endtask

  initial begin
    rst = 1'b1; imem_gnt = 1'b1; imem_rvalid = 1'b0; imem_rdata = '0;
    redirect = 1'b0; redirect_pc = '0; id_ready = 1'b1; hold_rsp = 1'b0;
    gnt2 = 1'b1; rvalid2 = 1'b0; rdata2 = '0; redirect2 = 1'b0;
    redirect_pc2 = '0; ready2 = 1'b1; hs2_q = 1'b0;

    // reset values
    @(negedge clk); #1;
    check("rst_valid", id_valid, 1'b0);
    check("rst_req",   imem_req, 1'b0);
    check("rst_instr", id_instr, 32'h0000_0013);
    check("rst_pc",    id_pc,    32'h0);
    check("rst_fault", id_fault, 1'b0);

    // streaming with ready=1, one-cycle responses
    do_reset();
    check("boot_req", imem_req, 1'b0);
    tick();
    check("c1_req",   imem_req,  1'b1);
    check("c1_addr",  imem_addr, 32'h0);
    check("w_addr0",  addr2,     32'hFFFF_FFF8);
    tick();
    check("c2_addr",  imem_addr, 32'h4);
    check("w_addr1",  addr2,     32'hFFFF_FFFC);
    tick();
    check("c3_valid", id_valid,  1'b1);
    check("c3_pc",    id_pc,     32'h0);
    check("c3_instr", id_instr,  32'hA5A5_0000);
    check("w_addr2",  addr2,     32'h0000_0000);
    tick();
    check("c4_pc",    id_pc,     32'h4);
    check("c4_instr", id_instr,  32'hA5A5_0004);
    tick();
    check("c5_pc",    id_pc,     32'h8);
    tick();
    check("c6_pc",    id_pc,     32'hC);
    check("c6_valid", id_valid,  1'b1);

    // backpressure: decode stalls six cycles
    id_ready = 1'b0;
    do_reset();
    tick(); tick(); tick();
    check("bp_req3", imem_req, 1'b0);
    tick();
    check("bp_req4", imem_req, 1'b0);
    tick();
    check("bp_req5",   imem_req, 1'b0);
    check("bp_valid5", id_valid, 1'b1);
    check("bp_pc5",    id_pc,    32'h0);
    id_ready = 1'b1; #1;
    check("bp_req6",   imem_req,  1'b1);
    check("bp_addr6",  imem_addr, 32'h8);
    check("bp_pc6",    id_pc,     32'h0);
    check("bp_instr6", id_instr,  32'hA5A5_0000);
    tick();
    check("bp_pc7",    id_pc,     32'h4);
    check("bp_instr7", id_instr,  32'hA5A5_0004);

    // redirect with two responses outstanding
    do_reset();
    hold_rsp = 1'b1;
    tick(); tick(); tick();
    check("fl_req_full", imem_req, 1'b0);
    redirect = 1'b1; redirect_pc = 32'h100;
    tick();
    redirect = 1'b0; hold_rsp = 1'b0; #1;
    check("fl_req4",   imem_req, 1'b0);
    check("fl_valid4", id_valid, 1'b0);
    tick();
    check("fl_req5",   imem_req, 1'b0);
    check("fl_valid5", id_valid, 1'b0);
    tick();
    check("fl_req6",   imem_req,  1'b1);
    check("fl_addr6",  imem_addr, 32'h100);
    check("fl_valid6", id_valid,  1'b0);
    tick();
    check("fl_addr7",  imem_addr, 32'h104);
    check("fl_valid7", id_valid,  1'b0);
    tick();
    check("fl_pc8",    id_pc,    32'h100);
    check("fl_instr8", id_instr, 32'hA5A5_0100);
    tick();
    check("fl_pc9",    id_pc,    32'h104);

    // redirect coincident with rvalid and gnt
    do_reset();
    tick(); tick();
    redirect = 1'b1; redirect_pc = 32'h40;
    tick();
    redirect = 1'b0; #1;
    check("co_valid3", id_valid,  1'b0);
    check("co_req3",   imem_req,  1'b1);
    check("co_addr3",  imem_addr, 32'h40);
    tick(); tick();
    check("co_valid5", id_valid,  1'b1);
    check("co_pc5",    id_pc,     32'h40);
    check("co_instr5", id_instr,  32'hA5A5_0040);

    // misaligned redirect target
    id_ready = 1'b0;
    do_reset();
    redirect = 1'b1; redirect_pc = 32'h102;
    tick();
    redirect = 1'b0; #1;
`ifdef IFETCH_MISALIGN_CHK_EN
    check("ma_valid", id_valid, 1'b1);
    check("ma_fault", id_fault, 1'b1);
    check("ma_pc",    id_pc,    32'h102);
    check("ma_instr", id_instr, 32'h0000_0013);
    check("ma_req1",  imem_req, 1'b0);
    tick();
    check("ma_req2",  imem_req, 1'b0);
    redirect = 1'b1; redirect_pc = 32'h200;
    tick();
    redirect = 1'b0; #1;
    check("ma_req3",    imem_req,  1'b1);
    check("ma_addr3",   imem_addr, 32'h200);
    check("ma_valid3",  id_valid,  1'b0);
`else
    check("ma_fault1", id_fault,  1'b0);
    check("ma_req1",   imem_req,  1'b1);
    check("ma_addr1",  imem_addr, 32'h100);
    tick();
    check("ma_addr2",  imem_addr, 32'h104);
    tick();
    check("ma_valid3", id_valid,  1'b1);
    check("ma_pc3",    id_pc,     32'h100);
    check("ma_instr3", id_instr,  32'hA5A5_0100);
    check("ma_fault3", id_fault,  1'b0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
